// File: rtl/serial_pkg.sv
// Shared definitions for the 10-bit serial link: frame layout, line levels and
// the state encoding used by both the transmitter and the receiver.
package serial_pkg;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GUARD = 2'd2
  } serial_state_e;

  // Frame = start bit + payload + stop bit.
  function automatic int frame_w(input int data_w);
    return data_w + 2;
  endfunction

endpackage

// File: rtl/bit_timer.sv
// Bit-period timer: bit_tick marks the last clk cycle of each bit period while
// run is high; tick_next says the following cycle will carry bit_tick.
module bit_timer #(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic bit_tick,
  output logic tick_next
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    bit_tick = run && (cnt_q == LAST);
    if (!run || bit_tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    tick_next = run && (cnt_d == LAST);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/piso_tx.sv
// Serial frame transmitter: accepts a byte on valid/ready, sends
// {start, data MSB-first, stop}, then holds the line high for a guard interval.
module piso_tx
  import serial_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 1,
  parameter int IDLE_BITS    = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              serial_out,
  output logic              busy,
  output logic              frame_done
);

  localparam int FRAME_W     = frame_w(DATA_W);
  localparam int BIT_CNT_W   = $clog2(FRAME_W);
  localparam int GUARD_CNT_W = $clog2(IDLE_BITS + 2);

  serial_state_e          state_q;
  logic [FRAME_W-1:0]     shreg_q;
  logic [BIT_CNT_W-1:0]   bit_cnt_q;
  logic [GUARD_CNT_W-1:0] guard_cnt_q;
  logic                   serial_out_q;
  logic                   tx_ready_q;
  logic                   busy_q;
  logic                   frame_done_q;

  logic timer_run;
  logic bit_tick;
  logic tick_next;
  logic stop_last_next;

  assign timer_run = (state_q == ST_SHIFT) || (state_q == ST_GUARD);

  bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk      (clk),
    .reset    (reset),
    .run      (timer_run),
    .bit_tick (bit_tick),
    .tick_next(tick_next)
  );

  // True when the coming cycle is the final cycle of the stop bit, so the
  // registered frame_done lines up with it.
  assign stop_last_next = tick_next &&
      ((bit_tick && (bit_cnt_q == BIT_CNT_W'(1))) ||
       (!bit_tick && (bit_cnt_q == '0)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      shreg_q      <= '0;
      bit_cnt_q    <= '0;
      guard_cnt_q  <= '0;
      serial_out_q <= IDLE_LEVEL;
      tx_ready_q   <= 1'b1;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (tx_valid && tx_ready_q) begin
            shreg_q      <= {START_BIT, tx_data, STOP_BIT};
            bit_cnt_q    <= BIT_CNT_W'(FRAME_W - 1);
            serial_out_q <= START_BIT;
            tx_ready_q   <= 1'b0;
            busy_q       <= 1'b1;
            state_q      <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          frame_done_q <= stop_last_next;
          if (bit_tick) begin
            if (bit_cnt_q == '0) begin
              serial_out_q <= IDLE_LEVEL;
              if (IDLE_BITS > 0) begin
                guard_cnt_q <= GUARD_CNT_W'(IDLE_BITS - 1);
                state_q     <= ST_GUARD;
              end else begin
                tx_ready_q <= 1'b1;
                busy_q     <= 1'b0;
                state_q    <= ST_IDLE;
              end
            end else begin
              shreg_q      <= {shreg_q[FRAME_W-2:0], 1'b1};
              serial_out_q <= shreg_q[FRAME_W-2];
              bit_cnt_q    <= bit_cnt_q - BIT_CNT_W'(1);
            end
          end
        end
        ST_GUARD: begin
          if (bit_tick) begin
            if (guard_cnt_q == '0) begin
              tx_ready_q <= 1'b1;
              busy_q     <= 1'b0;
              state_q    <= ST_IDLE;
            end else begin
              guard_cnt_q <= guard_cnt_q - GUARD_CNT_W'(1);
            end
          end
        end
        default: begin
          serial_out_q <= IDLE_LEVEL;
          tx_ready_q   <= 1'b1;
          busy_q       <= 1'b0;
          state_q      <= ST_IDLE;
        end
      endcase
    end
  end

  assign serial_out = serial_out_q;
  assign tx_ready   = tx_ready_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule
